// File: rtl/mips_pkg.sv
// Shared definitions for the instruction memory and its loader: loader state encoding,
// memory geometry and the running-checksum helper.
package mips_pkg;

   localparam int IMEM_DEPTH = 256;
   localparam int INSN_W     = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_HI = 3'd1,
      LEN_LO = 3'd2,
      DATA   = 3'd3,
      CSUM   = 3'd4,
      DONE   = 3'd5,
      ERR    = 3'd6
   } loader_state_t;

   function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] b);
      return csum ^ b;
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Shifts stream bytes MSB-first into a word and pulses word_valid the cycle after the
// final byte of a word has been accepted.
module byte_packer
   import mips_pkg::*;
#(
   parameter int WORD_W = INSN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              byte_en,
   input  logic [7:0]        byte_data,
   output logic [WORD_W-1:0] word,
   output logic              word_valid
);

   localparam int BYTES = WORD_W / 8;
   localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [CNT_W-1:0]  cnt_r;
   logic [WORD_W-1:0] shift_r;
   logic              valid_r;
   logic              last_byte_s;

   assign last_byte_s = (cnt_r == CNT_W'(BYTES - 1));
   assign word        = shift_r;
   assign word_valid  = valid_r;

   // Byte shift register, byte-in-word counter and the one-cycle word strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r   <= '0;
         shift_r <= '0;
         valid_r <= 1'b0;
      end else if (clear) begin
         cnt_r   <= '0;
         valid_r <= 1'b0;
      end else begin
         valid_r <= byte_en & last_byte_s;
         if (byte_en) begin
            shift_r <= (shift_r << 8) | WORD_W'(byte_data);
            cnt_r   <= last_byte_s ? '0 : cnt_r + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding the CPU in reset.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module imem_loader
   import mips_pkg::*;
#(
   parameter int WORD_W = INSN_W,
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output logic [15:0]       word_count
);

   loader_state_t     state_r, state_s;
   logic [7:0]        len_hi_r;
   logic [15:0]       len_r;
   logic [ADDR_W-3:0] word_idx_r;
   logic [15:0]       word_count_r;
   logic [15:0]       length_s;
   logic              accept_s;
   logic              start_ok_s;
   logic              last_word_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_r;
`endif

   assign accept_s    = byte_valid & byte_ready;
   assign start_ok_s  = start & ((state_r == IDLE) | (state_r == DONE) | (state_r == ERR));
   assign length_s    = {len_hi_r, byte_data};
   assign last_word_s = (word_count_r == (len_r - 16'd1));
   assign wr_addr     = {word_idx_r, 2'b00};
   assign word_count  = word_count_r;

   byte_packer #(.WORD_W(WORD_W)) u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (start_ok_s),
      .byte_en    (accept_s & (state_r == DATA)),
      .byte_data  (byte_data),
      .word       (wr_data),
      .word_valid (wr_en)
   );

   // Next-state logic for the frame parser.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE, DONE, ERR: begin
            if (start) state_s = LEN_HI;
            else       state_s = state_r;
         end
         LEN_HI: begin
            if (accept_s) state_s = LEN_LO;
            else          state_s = state_r;
         end
         LEN_LO: begin
            if (!accept_s)                             state_s = state_r;
            else if ({16'd0, length_s} > 32'(DEPTH))   state_s = ERR;
`ifdef IMEM_LOADER_CHECKSUM_EN
            else if (length_s == 16'd0)                state_s = CSUM;
`else
            else if (length_s == 16'd0)                state_s = DONE;
`endif
            else                                       state_s = DATA;
         end
         DATA: begin
            // Leave only once the final word has actually been written.
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (wr_en && last_word_s) state_s = CSUM;
`else
            if (wr_en && last_word_s) state_s = DONE;
`endif
            else                      state_s = state_r;
         end
         CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (!accept_s)                state_s = state_r;
            else if (byte_data == csum_r) state_s = DONE;
            else                          state_s = ERR;
`else
            state_s = IDLE;
`endif
         end
         default: state_s = IDLE;
      endcase
   end

   // Status and handshake decode from the current state.
   always_comb begin
      byte_ready = 1'b0;
      cpu_hold   = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      case (state_r)
         LEN_HI, LEN_LO, DATA, CSUM: begin
            byte_ready = ~wr_en;
            cpu_hold   = 1'b1;
         end
         DONE:    done = 1'b1;
         ERR:     err  = 1'b1;
         default: cpu_hold = 1'b0;
      endcase
   end

   // State, length, address/count and checksum registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         len_hi_r     <= 8'd0;
         len_r        <= 16'd0;
         word_idx_r   <= '0;
         word_count_r <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_r       <= 8'd0;
`endif
      end else begin
         state_r <= state_s;
         if (start_ok_s) begin
            word_idx_r   <= '0;
            word_count_r <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r       <= 8'd0;
`endif
         end else begin
            if (accept_s && (state_r == LEN_HI)) len_hi_r <= byte_data;
            if (accept_s && (state_r == LEN_LO)) len_r    <= length_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (accept_s && (state_r != CSUM))   csum_r   <= csum_update(csum_r, byte_data);
`endif
            if (wr_en) begin
               word_idx_r   <= word_idx_r + 1'b1;
               word_count_r <= word_count_r + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes the expected memory writes, a negedge
// monitor pops and compares them; frame outcomes come from a simple reference model.
module tb_imem_loader;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        cpu_hold;
   logic        done;
   logic        err;
   logic [15:0] word_count;

   int          errors = 0;
   int          checks = 0;
   logic [63:0] exp_q[$];
   logic [63:0] exp_w;
   logic [31:0] prog[$];

   imem_loader #(.WORD_W(32), .DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .err        (err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: every write must match the next expected one; status invariants every cycle.
   always @(negedge clk) begin
      if (!reset) begin
         chk("done_and_err", 64'(done & err), 64'd0);
         chk("ready_during_write", 64'(byte_ready & wr_en), 64'd0);
         if (wr_en) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr %h data %h, expected no write", wr_addr, wr_data);
            end else begin
               exp_w = exp_q.pop_front();
               chk("write_addr_data", {wr_addr, wr_data}, exp_w);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_reset_values(input string name);
      chk({name, "_flags"}, 64'({byte_ready, wr_en, cpu_hold, done, err}), 64'd0);
      chk({name, "_addr_data"}, {wr_addr, wr_data}, 64'd0);
      chk({name, "_count"}, 64'(word_count), 64'd0);
   endtask

   // Present one byte after a random idle gap and hold it until the loader takes it.
   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int gap;
      int waited;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      byte_valid = 1'b0;
      repeat (gap) tick();
      byte_valid = 1'b1;
      byte_data  = b;
      waited     = 0;
      forever begin
         @(negedge clk);
         if (byte_ready) break;
         waited++;
         if (waited > 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: byte %h not accepted, expected acceptance", b);
            byte_valid = 1'b0;
            return;
         end
      end
      tick();
      byte_valid = 1'b0;
   endtask

   // Reference model: a frame of N words either writes word i to byte address 4*i and
   // finishes with done, or (N > DEPTH / bad checksum) ends with err.
   task automatic run_load(input int n, input int max_gap, input int inject_at, input bit csum_flip);
      logic [7:0] frame[$];
      logic [7:0] x;
      logic [31:0] w;
      bit  bad_len;
      bit  exp_err;
      int  budget;
      int  last_i;
      bad_len = (n > DEPTH);
      exp_err = bad_len | csum_flip;
      frame.push_back(8'(n >> 8));
      frame.push_back(8'(n));
      if (!bad_len) begin
         for (int i = 0; i < n; i++) begin
            w = prog[i];
            for (int k = 3; k >= 0; k--) frame.push_back(w[8*k +: 8]);
            exp_q.push_back({32'(i * 4), w});
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (!bad_len) begin
         x = 8'd0;
         foreach (frame[i]) x = x ^ frame[i];
         frame.push_back(csum_flip ? (x ^ 8'h01) : x);
      end
`else
      x = 8'd0;
`endif
      pulse_start();
      chk("hold_after_start", 64'({cpu_hold, done, err}), 64'b100);
      chk("count_after_start", 64'(word_count), 64'd0);
      last_i = frame.size() - 1;
      for (int i = 0; i <= last_i; i++) begin
         if (i == inject_at) pulse_start();
         send_byte(frame[i], max_gap);
`ifndef IMEM_LOADER_CHECKSUM_EN
         if (!bad_len && n > 0 && i == last_i) begin
            chk("latency_wr_en", 64'({wr_en, done, cpu_hold}), 64'b101);
            tick();
            chk("latency_done", 64'({done, cpu_hold}), 64'b10);
         end
`endif
      end
      budget = 0;
      while (!(done | err) && budget < 50) begin
         tick();
         budget++;
      end
      chk("load_finished", 64'(done | err), 64'd1);
      chk("done_err", 64'({done, err}), exp_err ? 64'b01 : 64'b10);
      chk("word_count", 64'(word_count), bad_len ? 64'd0 : 64'(n));
      chk("cpu_hold_released", 64'(cpu_hold), 64'd0);
      chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic random_prog(input int n);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back($urandom());
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'd0;
      repeat (3) tick();
      check_reset_values("in_reset");
      reset = 1'b0;
      tick();
      check_reset_values("idle");

      // Bytes without a start must be ignored.
      byte_valid = 1'b1;
      byte_data  = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("idle_no_ready", 64'(byte_ready), 64'd0);
         tick();
      end
      byte_valid = 1'b0;

      prog = '{32'h20100007, 32'h20110001, 32'h12000004, 32'h72308802, 32'h2210FFFF,
               32'h08000002, 32'h00000000, 32'h00000000, 32'hAC110000};
      run_load(9, 0, -1, 1'b0);
      run_load(257, 0, -1, 1'b0);
      run_load(9, 3, 7, 1'b0);

      for (int r = 0; r < 3; r++) begin
         random_prog(int'($urandom_range(1, 8)));
         run_load(prog.size(), 2, int'($urandom_range(2, 6)), 1'b0);
      end

      run_load(0, 0, -1, 1'b0);
      random_prog(DEPTH);
      run_load(DEPTH, 0, -1, 1'b0);

      // Abort after two of four words, then a fresh one-word load.
      random_prog(4);
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h04, 0);
      for (int i = 0; i < 2; i++) exp_q.push_back({32'(i * 4), prog[i]});
      for (int i = 0; i < 2; i++)
         for (int k = 3; k >= 0; k--) send_byte(prog[i][8*k +: 8], 1);
      tick();
      chk("writes_before_abort", 64'(exp_q.size()), 64'd0);
      chk("count_before_abort", 64'(word_count), 64'd2);
      reset = 1'b1;
      tick();
      check_reset_values("abort");
      reset = 1'b0;
      tick();
      prog = '{32'h00008020};
      run_load(1, 0, -1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      prog = '{32'h2010FFFF};
      run_load(1, 0, -1, 1'b0);
      run_load(1, 0, -1, 1'b1);
      random_prog(5);
      run_load(5, 2, -1, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
